// File: rtl/line_win_ctrl_pkg.sv
// Shared types and constants for the 3x3 line-window controller.
// The ring holds one spare line so writing can continue while three lines are read.
package line_win_ctrl_pkg;

  localparam int RING_DEPTH = 4;
  localparam int SEL_W      = $clog2(RING_DEPTH);
  localparam int WIN_TAPS   = 3;
  localparam int WIN_PIX    = WIN_TAPS * WIN_TAPS;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/line_win_ctrl_if.sv
// Pixel-stream input and window output bundle of the line-window controller.
interface line_win_ctrl_if
  import line_win_ctrl_pkg::*;
#(
  parameter int PIX_W = 8
);

  logic [PIX_W-1:0]         pixel_in;
  logic                     pixel_in_valid;
  logic                     pixel_in_ready;
  logic [WIN_PIX*PIX_W-1:0] pixel_data_out;
  logic                     pixel_data_valid_out;
  logic                     line_done_intr;

  modport master (
    output pixel_in, pixel_in_valid,
    input  pixel_in_ready, pixel_data_out, pixel_data_valid_out, line_done_intr
  );

  modport slave (
    input  pixel_in, pixel_in_valid,
    output pixel_in_ready, pixel_data_out, pixel_data_valid_out, line_done_intr
  );

endinterface

// File: rtl/line_buffer.sv
// One image line of storage: single write port, three adjacent entries read combinationally.
// Contents are never reset; stale data is harmless because reads are gated by line counts.
module line_buffer
  import line_win_ctrl_pkg::*;
#(
  parameter  int IMG_WIDTH = 512,
  parameter  int PIX_W     = 8,
  localparam int ADDR_W    = $clog2(IMG_WIDTH)
) (
  input  logic                        Clk,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [PIX_W-1:0]            wr_data,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [WIN_TAPS*PIX_W-1:0]   rd_data
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // rd_addr never exceeds IMG_WIDTH-3, so rd_addr+2 stays inside the line
  generate
    for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_tap
      assign rd_data[gi*PIX_W +: PIX_W] = mem[rd_addr + ADDR_W'(gi)];
    end
  endgenerate

endmodule

// File: rtl/line_win_ctrl.sv
// Streams raster pixels into a 4-line ring and emits one registered 3x3 window
// per column of each output line, with a one-cycle interrupt on the last window.
module line_win_ctrl
  import line_win_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = 8
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Enable,
  line_win_ctrl_if.slave  win
);

  localparam int ADDR_W = $clog2(IMG_WIDTH);
  localparam int LF_W   = $clog2(RING_DEPTH + 1);
  localparam logic [ADDR_W-1:0] WR_LAST = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(IMG_WIDTH - 3);

  rd_state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]         wr_ptr_reg, rd_col_reg;
  logic [SEL_W-1:0]          wr_sel_reg, rd_sel_reg;
  logic [LF_W-1:0]           lines_filled_reg;
  logic [WIN_PIX*PIX_W-1:0]  win_data_reg, window;
  logic                      win_valid_reg, intr_reg;
  logic                      ready, accept, wr_line_done, rd_line_done, rd_active;
  logic [WIN_TAPS*PIX_W-1:0] buf_taps [RING_DEPTH];

  assign ready        = (lines_filled_reg < LF_W'(RING_DEPTH));
  assign accept       = win.pixel_in_valid && ready;
  assign wr_line_done = accept && (wr_ptr_reg == WR_LAST);
  assign rd_line_done = rd_active && (rd_col_reg == RD_LAST);

  // Write side and ring occupancy
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_reg       <= '0;
      wr_sel_reg       <= '0;
      lines_filled_reg <= '0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_line_done ? '0 : wr_ptr_reg + ADDR_W'(1);
        if (wr_line_done) begin
          wr_sel_reg <= wr_sel_reg + SEL_W'(1);
        end
      end
      case ({wr_line_done, rd_line_done})
        2'b10:   lines_filled_reg <= lines_filled_reg + LF_W'(1);
        2'b01:   lines_filled_reg <= lines_filled_reg - LF_W'(1);
        default: lines_filled_reg <= lines_filled_reg;
      endcase
    end
  end

  // Read FSM: state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= RD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Read FSM: next state; a line always leaves through IDLE, giving the mandatory gap
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_IDLE: if (Enable && (lines_filled_reg >= LF_W'(RING_DEPTH - 1))) state_next = RD_READ;
      RD_READ: if (rd_col_reg == RD_LAST) state_next = RD_IDLE;
      default: state_next = RD_IDLE;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    rd_active = (state_reg == RD_READ);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_col_reg <= '0;
      rd_sel_reg <= '0;
    end else if (rd_active) begin
      rd_col_reg <= rd_line_done ? '0 : rd_col_reg + ADDR_W'(1);
      if (rd_line_done) begin
        rd_sel_reg <= rd_sel_reg + SEL_W'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < RING_DEPTH; gi++) begin : g_buf
      line_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .PIX_W     (PIX_W)
      ) u_line_buffer (
        .Clk     (Clk),
        .wr_en   (accept && (wr_sel_reg == SEL_W'(gi))),
        .wr_addr (wr_ptr_reg),
        .wr_data (win.pixel_in),
        .rd_addr (rd_col_reg),
        .rd_data (buf_taps[gi])
      );
    end
  endgenerate

  // Row gi of the window comes from ring slot rd_sel+gi, wrapping within the ring
  generate
    for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_row
      assign window[gi*WIN_TAPS*PIX_W +: WIN_TAPS*PIX_W] = buf_taps[rd_sel_reg + SEL_W'(gi)];
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      win_data_reg  <= '0;
      win_valid_reg <= 1'b0;
      intr_reg      <= 1'b0;
    end else begin
      win_valid_reg <= rd_active;
      intr_reg      <= rd_line_done;
      if (rd_active) begin
        win_data_reg <= window;
      end
    end
  end

  assign win.pixel_in_ready       = ready;
  assign win.pixel_data_out       = win_data_reg;
  assign win.pixel_data_valid_out = win_valid_reg;
  assign win.line_done_intr       = intr_reg;

endmodule

// File: tb/tb_line_win_ctrl.sv
// Scoreboard bench for line_win_ctrl at IMG_WIDTH=8: expected windows are queued as
// lines are streamed in and popped as the controller emits them.
module tb_line_win_ctrl;
  import line_win_ctrl_pkg::*;

  localparam int W    = 8;
  localparam int PW   = 8;
  localparam int NWIN = W - 2;

  typedef struct {
    logic [71:0] data;
    logic        intr;
  } win_t;

  logic Clk    = 1'b0;
  logic Rst_n  = 1'b0;
  logic Enable = 1'b0;

  line_win_ctrl_if #(.PIX_W(PW)) pif ();

  line_win_ctrl #(
    .IMG_WIDTH (W),
    .PIX_W     (PW)
  ) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Enable (Enable),
    .win    (pif.slave)
  );

  always #5 Clk = ~Clk;

  win_t        exp_q [$];
  win_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          win_cnt = 0;
  int          last_acc_cyc = 0;
  int          first_valid_cyc = 0;
  logic [71:0] first_win = '0;
  logic [71:0] second_line_first = '0;
  logic        track_ready = 1'b0;
  logic        ready_dropped = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int row, input int col);
    return PW'(row * 16 + col);
  endfunction

  function automatic logic [71:0] exp_win(input int top, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*PW +: PW] = pix(top + r, col + c);
    return w;
  endfunction

  task automatic push_line(input int top);
    win_t e;
    for (int c = 0; c < NWIN; c++) begin
      e.data = exp_win(top, c);
      e.intr = (c == NWIN - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (track_ready && !pif.pixel_in_ready) ready_dropped = 1'b1;
      if (pif.line_done_intr)
        chk("intr_has_valid", 72'(pif.pixel_data_valid_out), 72'(1));
      if (pif.pixel_data_valid_out) begin
        if (win_cnt == 0) begin
          first_win       = pif.pixel_data_out;
          first_valid_cyc = cyc;
        end
        if (win_cnt == NWIN) second_line_first = pif.pixel_data_out;
        $display("window %0d data=%h intr=%b", win_cnt, pif.pixel_data_out, pif.line_done_intr);
        win_cnt++;
        chk("win_expected", 72'(exp_q.size() != 0), 72'(1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("win_data", pif.pixel_data_out, mon_e.data);
          chk("win_intr", 72'(pif.line_done_intr), 72'(mon_e.intr));
        end
      end
    end
  end

  task automatic do_reset();
    Enable             = 1'b0;
    pif.pixel_in_valid = 1'b0;
    pif.pixel_in       = '0;
    Rst_n              = 1'b0;
    #1;
    exp_q.delete();
    win_cnt = 0;
    chk("rst_valid", 72'(pif.pixel_data_valid_out), 72'(0));
    chk("rst_data",  pif.pixel_data_out, 72'(0));
    chk("rst_intr",  72'(pif.line_done_intr), 72'(0));
    chk("rst_ready", 72'(pif.pixel_in_ready), 72'(1));
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_pixel(input logic [PW-1:0] v);
    int waited;
    waited             = 0;
    pif.pixel_in       = v;
    pif.pixel_in_valid = 1'b1;
    @(negedge Clk);
    while (!pif.pixel_in_ready && waited < 200) begin
      waited++;
      @(negedge Clk);
    end
    if (!pif.pixel_in_ready) chk("ready_timeout", 72'(pif.pixel_in_ready), 72'(1));
    @(posedge Clk);
    #1;
    last_acc_cyc       = cyc;
    pif.pixel_in_valid = 1'b0;
  endtask

  task automatic send_line(input int row, input logic en_after_first);
    for (int c = 0; c < W; c++) begin
      send_pixel(pix(row, c));
      if (c == 0 && en_after_first) Enable = 1'b1;
    end
  endtask

  task automatic wait_windows(input int n, input int q_left, input string tag);
    int k;
    k = 0;
    while (win_cnt < n && k < 500) begin
      @(posedge Clk);
      k++;
    end
    repeat (20) @(posedge Clk);
    #1;
    chk(tag, 72'(win_cnt), 72'(n));
    chk({tag, "_queue"}, 72'(exp_q.size()), 72'(q_left));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_ref;
    int k;

    // Three lines with Enable high: six windows, latency and first-window content
    do_reset();
    Enable = 1'b1;
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    lat_ref = last_acc_cyc;
    push_line(0);
    wait_windows(NWIN, 0, "t1_windows");
    chk("t1_first_win", first_win, 72'h222120121110020100);
    chk("t1_latency", 72'(first_valid_cyc - lat_ref), 72'(2));

    // Five lines back to back: ready never drops, three output lines
    do_reset();
    Enable        = 1'b1;
    ready_dropped = 1'b0;
    track_ready   = 1'b1;
    for (int r = 0; r < 5; r++) begin
      send_line(r, 1'b0);
      if (r >= 2) push_line(r - 2);
    end
    wait_windows(3 * NWIN, 0, "t2_windows");
    track_ready = 1'b0;
    chk("t2_ready_dropped", 72'(ready_dropped), 72'(0));
    chk("t2_line2_top_row", 72'(second_line_first[23:0]), 72'(24'h121110));

    // Enable low: ring fills and stalls, then a single Enable pulse drains one line
    do_reset();
    for (int r = 0; r < 4; r++) begin
      send_line(r, 1'b0);
      if (r >= 2) push_line(r - 2);
    end
    chk("t3_ready_low", 72'(pif.pixel_in_ready), 72'(0));
    pif.pixel_in       = pix(4, 0);
    pif.pixel_in_valid = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    pif.pixel_in_valid = 1'b0;
    chk("t3_no_valid", 72'(win_cnt), 72'(0));
    chk("t3_still_stalled", 72'(pif.pixel_in_ready), 72'(0));
    Enable = 1'b1;
    @(posedge Clk);
    #1;
    Enable = 1'b0;
    wait_windows(NWIN, NWIN, "t3_first_line");
    chk("t3_ready_back", 72'(pif.pixel_in_ready), 72'(1));
    send_line(4, 1'b0);
    push_line(2);
    Enable = 1'b1;
    wait_windows(3 * NWIN, 0, "t3_all_lines");

    // Line-write completion lands on the same edge as read-line completion
    do_reset();
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    push_line(0);
    send_line(3, 1'b1);
    push_line(1);
    wait_windows(2 * NWIN, 0, "t4_windows");
    chk("t4_ready", 72'(pif.pixel_in_ready), 72'(1));

    // Reset in the middle of an output line, then a clean restart
    do_reset();
    Enable = 1'b1;
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    push_line(0);
    k = 0;
    while (win_cnt < 3 && k < 200) begin
      @(negedge Clk);
      k++;
    end
    chk("t5_windows_before_rst", 72'(win_cnt), 72'(3));
    do_reset();
    Enable = 1'b1;
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    push_line(0);
    wait_windows(NWIN, 0, "t5_windows");
    chk("t5_first_win", first_win, 72'h222120121110020100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
